fifo_sync: RTL and testbench



---
 rtl/fifo_sync.sv | 130 +++++++++++++
 tb/tb_fifo_sync.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and FWFT or registered read.
// Define FIFO_SYNC_ERR_EN to add sticky overflow/underflow flags cleared by err_clr.
module fifo_sync #(
  parameter int    DATASIZE     = 8,
  parameter int    ADDRSIZE     = 4,
  parameter string FALLTHROUGH  = "TRUE",
  parameter int    AFULL_LEVEL  = (2**ADDRSIZE) - 2,
  parameter int    AEMPTY_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [DATASIZE-1:0] wdata,
  output logic                full,
  output logic                afull,
  input  logic                ren,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                empty,
  output logic                aempty,
  output logic [ADDRSIZE:0]   count
`ifdef FIFO_SYNC_ERR_EN
  ,
  input  logic                err_clr,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam int                DEPTH     = 2**ADDRSIZE;
  localparam logic [ADDRSIZE:0] DepthCnt  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AfullCnt  = (ADDRSIZE+1)'(AFULL_LEVEL);
  localparam logic [ADDRSIZE:0] AemptyCnt = (ADDRSIZE+1)'(AEMPTY_LEVEL);
  localparam bit                IsFwft    = (FALLTHROUGH == "TRUE");

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0]   count_q, count_d;
  logic                wAccept, rAccept;

  // All status flags decode the count registered at the start of the cycle,
  // so a same-cycle read never makes room for a write (and vice versa).
  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign afull   = (count_q >= AfullCnt);
  assign aempty  = (count_q <= AemptyCnt);
  assign count   = count_q;
  assign wAccept = wen && !full;
  assign rAccept = ren && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wAccept) wptr_d = wptr_q + ADDRSIZE'(1);
    if (rAccept) rptr_d = rptr_q + ADDRSIZE'(1);
    if (wAccept && !rAccept) begin
      count_d = count_q + (ADDRSIZE+1)'(1);
    end else if (rAccept && !wAccept) begin
      count_d = count_q - (ADDRSIZE+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wAccept && !rst) mem[wptr_q] <= wdata;
  end

  if (IsFwft) begin : g_fwft
    assign rdata  = empty ? '0 : mem[rptr_q];
    assign rvalid = !empty;
  end else begin : g_reg
    logic [DATASIZE-1:0] rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rAccept;
      if (rAccept) rdata_d = mem[rptr_q];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

`ifdef FIFO_SYNC_ERR_EN
  logic overflow_q, underflow_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wen && full) overflow_q <= 1'b1;
      else if (err_clr) overflow_q <= 1'b0;
      if (ren && empty) underflow_q <= 1'b1;
      else if (err_clr) underflow_q <= 1'b0;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: one FWFT and one registered-read instance, each checked
// against a queue scoreboard that tracks accepted writes and reads.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       wenF = 1'b0, renF = 1'b0, errClrF = 1'b0;
  logic [7:0] wdataF = '0;
  logic       fullF, afullF, rvalidF, emptyF, aemptyF;
  logic [7:0] rdataF;
  logic [4:0] countF;

  logic       wenR = 1'b0, renR = 1'b0, errClrR = 1'b0;
  logic [7:0] wdataR = '0;
  logic       fullR, afullR, rvalidR, emptyR, aemptyR;
  logic [7:0] rdataR;
  logic [4:0] countR;

`ifdef FIFO_SYNC_ERR_EN
  logic       ovfF, unfF, ovfR, unfR;
  logic       expOvfF = 1'b0, expUnfF = 1'b0, expOvfR = 1'b0, expUnfR = 1'b0;
`endif

  int         nCompared   = 0;
  int         nMismatched = 0;

  logic [7:0] qF[$];
  logic [7:0] qR[$];
  logic [7:0] expRdataR  = '0;
  logic       expRvalidR = 1'b0;

  always #5 clk = ~clk;

  fifo_sync #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("TRUE")) dutF (
    .clk(clk), .rst(rst), .wen(wenF), .wdata(wdataF), .full(fullF), .afull(afullF),
    .ren(renF), .rdata(rdataF), .rvalid(rvalidF), .empty(emptyF), .aempty(aemptyF),
    .count(countF)
`ifdef FIFO_SYNC_ERR_EN
    , .err_clr(errClrF), .overflow(ovfF), .underflow(unfF)
`endif
  );

  fifo_sync #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("FALSE")) dutR (
    .clk(clk), .rst(rst), .wen(wenR), .wdata(wdataR), .full(fullR), .afull(afullR),
    .ren(renR), .rdata(rdataR), .rvalid(rvalidR), .empty(emptyR), .aempty(aemptyR),
    .count(countR)
`ifdef FIFO_SYNC_ERR_EN
    , .err_clr(errClrR), .overflow(ovfR), .underflow(unfR)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutputF();
    int n;
    n = qF.size();
    check("F.count",  32'(countF), n);
    check("F.full",   fullF,   n == 16);
    check("F.empty",  emptyF,  n == 0);
    check("F.afull",  afullF,  n >= 14);
    check("F.aempty", aemptyF, n <= 2);
    check("F.rvalid", rvalidF, n != 0);
    check("F.rdata",  rdataF,  (n != 0) ? qF[0] : 8'h00);
`ifdef FIFO_SYNC_ERR_EN
    check("F.overflow",  ovfF, expOvfF);
    check("F.underflow", unfF, expUnfF);
`endif
  endtask

  task automatic checkOutputR();
    int n;
    n = qR.size();
    check("R.count",  32'(countR), n);
    check("R.full",   fullR,   n == 16);
    check("R.empty",  emptyR,  n == 0);
    check("R.afull",  afullR,  n >= 14);
    check("R.aempty", aemptyR, n <= 2);
    check("R.rvalid", rvalidR, expRvalidR);
    check("R.rdata",  rdataR,  expRdataR);
`ifdef FIFO_SYNC_ERR_EN
    check("R.overflow",  ovfR, expOvfR);
    check("R.underflow", unfR, expUnfR);
`endif
  endtask

  // One clock of stimulus on the FWFT instance; the scoreboard decides acceptance
  // from its own occupancy before the edge.
  task automatic applyStimulusF(input logic w, input logic [7:0] d, input logic r, input logic clr);
    logic wAcc, rAcc;
    wAcc = w && (qF.size() != 16);
    rAcc = r && (qF.size() != 0);
`ifdef FIFO_SYNC_ERR_EN
    if (w && qF.size() == 16) expOvfF = 1'b1; else if (clr) expOvfF = 1'b0;
    if (r && qF.size() == 0)  expUnfF = 1'b1; else if (clr) expUnfF = 1'b0;
`endif
    if (rAcc) void'(qF.pop_front());
    if (wAcc) qF.push_back(d);
    wenF = w; wdataF = d; renF = r; errClrF = clr;
    tick();
    wenF = 1'b0; renF = 1'b0; errClrF = 1'b0;
    checkOutputF();
  endtask

  task automatic applyStimulusR(input logic w, input logic [7:0] d, input logic r, input logic clr);
    logic wAcc, rAcc;
    wAcc = w && (qR.size() != 16);
    rAcc = r && (qR.size() != 0);
`ifdef FIFO_SYNC_ERR_EN
    if (w && qR.size() == 16) expOvfR = 1'b1; else if (clr) expOvfR = 1'b0;
    if (r && qR.size() == 0)  expUnfR = 1'b1; else if (clr) expUnfR = 1'b0;
`endif
    expRvalidR = rAcc;
    if (rAcc) expRdataR = qR.pop_front();
    if (wAcc) qR.push_back(d);
    wenR = w; wdataR = d; renR = r; errClrR = clr;
    tick();
    wenR = 1'b0; renR = 1'b0; errClrR = 1'b0;
    checkOutputR();
  endtask

  // Reset is held with write/read requests active to show it overrides them.
  task automatic doReset();
    rst = 1'b1;
    wenF = 1'b1; wdataF = 8'hEE; renF = 1'b1;
    wenR = 1'b1; wdataR = 8'hEE; renR = 1'b1;
    tick();
    rst = 1'b0;
    wenF = 1'b0; renF = 1'b0; wenR = 1'b0; renR = 1'b0;
    qF.delete();
    qR.delete();
    expRdataR  = '0;
    expRvalidR = 1'b0;
`ifdef FIFO_SYNC_ERR_EN
    expOvfF = 1'b0; expUnfF = 1'b0; expOvfR = 1'b0; expUnfR = 1'b0;
`endif
    checkOutputF();
    checkOutputR();
  endtask

  initial begin
    $display("[TB] tb_fifo_sync start");
    tick();
    doReset();

    // FWFT: fill with 0x11..0x1F, then 0x20 reaches full
    for (int i = 1; i <= 15; i++) applyStimulusF(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    applyStimulusF(1'b1, 8'h20, 1'b0, 1'b0);
    check("F.full_at16", fullF, 1'b1);

    // FWFT: drain all 16 words; after the last, rdata returns to 0
    for (int i = 0; i < 16; i++) applyStimulusF(1'b0, 8'h00, 1'b1, 1'b0);
    check("F.rdata_empty", rdataF, 8'h00);

    // FWFT: read+write while empty -> write kept, no pop
    applyStimulusF(1'b1, 8'h55, 1'b1, 1'b0);
    applyStimulusF(1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT: fill to 9, reset mid-operation, then a fresh word reads back
    for (int i = 0; i < 8; i++) applyStimulusF(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("F.count_9", 32'(countF), 9);
    doReset();
    applyStimulusF(1'b1, 8'hA5, 1'b0, 1'b0);
    check("F.rdata_A5", rdataF, 8'hA5);

    // Registered: one word, then 40 cycles of simultaneous read/write at count 1
    applyStimulusR(1'b1, 8'h30, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulusR(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    applyStimulusR(1'b0, 8'h00, 1'b0, 1'b0);

    // Registered: fill to full, then read+write while full drops the write
    for (int i = 0; i < 15; i++) applyStimulusR(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    applyStimulusR(1'b1, 8'hEE, 1'b1, 1'b0);
    applyStimulusR(1'b0, 8'h00, 1'b0, 1'b1);

    // Registered: read while empty is ignored
    for (int i = 0; i < 15; i++) applyStimulusR(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulusR(1'b0, 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
